// File: rtl/mac_pkg.sv
// Shared widths, FSM state type and precision helper for the MAC weight-feed path.
package mac_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PREC_W = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A precision of zero still emits one bit.
    function automatic logic [PREC_W-1:0] eff_prec(input logic [PREC_W-1:0] p);
        return (p == '0) ? PREC_W'(1) : p;
    endfunction

endpackage

// File: rtl/word_slot.sv
// Holding register for one operand word: data, remaining bit count and valid flag.
module word_slot
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    input  logic [PREC_W-1:0] load_prec,
    output logic [DATA_W-1:0] data,
    output logic [PREC_W-1:0] prec,
    output logic              valid
);

    // Load wins over clear, clear wins over shift; clear zeroes data so an idle slot shows 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            prec  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            prec  <= load_prec;
            valid <= 1'b1;
        end else if (clear) begin
            data  <= '0;
            prec  <= '0;
            valid <= 1'b0;
        end else if (shift) begin
            data  <= {1'b0, data[DATA_W-1:1]};
            prec  <= prec - PREC_W'(1);
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the bit-serial weight FIFO, LSB first, with a pending word slot.
module bit_serializer
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PREC_W-1:0] in_prec,
    input  logic              fifo_full,
    output logic              bit_valid,
    output logic              bit_out,
    output logic              bit_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] act_sr;
    logic [PREC_W-1:0] act_cnt;
    logic              act_valid;
    logic [DATA_W-1:0] pend_data;
    logic [PREC_W-1:0] pend_prec;
    logic              pend_valid;

    logic              accept;
    logic              complete;
    logic              act_load;
    logic              act_clear;
    logic              act_from_pend;
    logic              pend_load;
    logic              pend_clear;
    logic [DATA_W-1:0] act_load_data;
    logic [PREC_W-1:0] act_load_prec;
    logic [PREC_W-1:0] in_eff_prec;

    assign bit_out     = act_sr[0];
    assign bit_valid   = act_valid & ~fifo_full;
    assign bit_last    = act_valid & (act_cnt == PREC_W'(1));
    assign in_ready    = ~pend_valid;
    assign busy        = act_valid | pend_valid;

    assign accept      = in_valid & in_ready;
    assign complete    = bit_valid & bit_last;
    assign in_eff_prec = eff_prec(in_prec);

    // Load priority: refill from pend on completion, else take the incoming word directly when act frees up.
    always_comb begin
        state_nxt     = state;
        act_load      = 1'b0;
        act_clear     = 1'b0;
        act_from_pend = 1'b0;
        pend_load     = 1'b0;
        pend_clear    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    act_load  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (complete) begin
                    if (pend_valid) begin
                        act_load      = 1'b1;
                        act_from_pend = 1'b1;
                        pend_clear    = 1'b1;
                    end else if (accept) begin
                        act_load      = 1'b1;
                    end else begin
                        act_clear     = 1'b1;
                        state_nxt     = IDLE;
                    end
                end else if (accept) begin
                    pend_load = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign act_load_data = act_from_pend ? pend_data : in_data;
    assign act_load_prec = act_from_pend ? pend_prec : in_eff_prec;

    word_slot u_act (
        .clk       (clk),
        .rst       (rst),
        .load      (act_load),
        .clear     (act_clear),
        .shift     (bit_valid),
        .load_data (act_load_data),
        .load_prec (act_load_prec),
        .data      (act_sr),
        .prec      (act_cnt),
        .valid     (act_valid)
    );

    word_slot u_pend (
        .clk       (clk),
        .rst       (rst),
        .load      (pend_load),
        .clear     (pend_clear),
        .shift     (1'b0),
        .load_data (in_data),
        .load_prec (in_eff_prec),
        .data      (pend_data),
        .prec      (pend_prec),
        .valid     (pend_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            word_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (complete) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomised and directed bench for bit_serializer against a word-queue reference model.
module tb_bit_serializer;
    import mac_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [PREC_W-1:0] in_prec = '0;
    logic              fifo_full = 1'b0;
    logic              in_ready;
    logic              bit_valid;
    logic              bit_out;
    logic              bit_last;
    logic              busy;
    logic [CNT_W-1:0]  word_cnt;

    bit_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_prec   (in_prec),
        .fifo_full (fifo_full),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .bit_last  (bit_last),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue of words held by the block, each with its bits and read position.
    typedef struct {
        logic [15:0] data;
        int          prec;
        int          pos;
    } word_t;

    word_t       mq[$];
    logic [15:0] done_cnt;
    bit          cap[$];
    logic [15:0] sb_exp[$];
    logic [15:0] sb_acc;
    int          sb_pos;
    bit          rand_ff = 1'b0;

    always @(negedge clk) begin : model
        bit    ev;
        bit    rdy;
        int    p;
        word_t w;
        if (!rst) begin
            mq.delete();
            sb_exp.delete();
            done_cnt = '0;
            sb_acc   = '0;
            sb_pos   = 0;
            check("rst_bit_valid", 32'(bit_valid), 32'd0);
            check("rst_bit_out", 32'(bit_out), 32'd0);
            check("rst_bit_last", 32'(bit_last), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_word_cnt", 32'(word_cnt), 32'd0);
        end else begin
            ev  = (mq.size() > 0) && !fifo_full;
            rdy = (mq.size() < 2);
            check("bit_valid", 32'(bit_valid), 32'(ev));
            check("no_write_when_full", 32'(bit_valid & fifo_full), 32'd0);
            check("busy", 32'(busy), 32'(mq.size() > 0));
            check("in_ready", 32'(in_ready), 32'(rdy));
            check("word_cnt", 32'(word_cnt), 32'(done_cnt));
            if (mq.size() > 0) begin
                w = mq[0];
                check("bit_out", 32'(bit_out), 32'(w.data[w.pos]));
                check("bit_last", 32'(bit_last), 32'(w.pos == w.prec - 1));
            end else begin
                check("bit_last_idle", 32'(bit_last), 32'd0);
            end
            // Downstream FIFO view: rebuild words from written bits.
            if (bit_valid) begin
                cap.push_back(bit_out);
                if (sb_pos < 16) sb_acc[sb_pos] = bit_out;
                sb_pos++;
                if (bit_last) begin
                    if (sb_exp.size() == 0) check("fifo_word_unexpected", 32'(sb_acc), 32'hFFFF_FFFF);
                    else check("fifo_word", 32'(sb_acc), 32'(sb_exp.pop_front()));
                    sb_acc = '0;
                    sb_pos = 0;
                end
            end
            if (ev) begin
                w = mq[0];
                w.pos = w.pos + 1;
                if (w.pos == w.prec) begin
                    void'(mq.pop_front());
                    done_cnt = done_cnt + 16'd1;
                end else begin
                    mq[0] = w;
                end
            end
            if (in_valid && rdy) begin
                p = (in_prec == 0) ? 1 : int'(in_prec);
                w.data = in_data;
                w.prec = p;
                w.pos  = 0;
                mq.push_back(w);
                sb_exp.push_back(in_data & 16'((32'd1 << p) - 32'd1));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ff) fifo_full = ($urandom_range(0, 9) < 3);
    end

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [15:0] d, input logic [3:0] p);
        bit ok;
        bit r;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_prec  = p;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    // Counts busy cycles until idle, then returns just after the next rising edge.
    task automatic run_out(output int n);
        n = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        if (busy) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input string name, input logic [15:0] bits, input int n);
        check({name, "_len"}, 32'(cap.size()), 32'(n));
        for (int i = 0; i < n && i < cap.size(); i++) begin
            check(name, 32'(cap[i]), 32'(bits[i]));
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        cap.delete();
        send(16'h00B5, 4'd8);
        run_out(n);
        check("single_cycles", 32'(n), 32'd8);
        check_seq("single_seq", 16'h00B5, 8);
        check("single_word_cnt", 32'(word_cnt), 32'd1);
        check("single_busy", 32'(busy), 32'd0);

        cap.delete();
        send(16'h0009, 4'd4);
        send(16'h0006, 4'd4);
        check("b2b_in_ready_low", 32'(in_ready), 32'd0);
        run_out(n);
        check("b2b_cycles", 32'(n), 32'd7);
        check_seq("b2b_seq", 16'h0069, 8);
        check("b2b_word_cnt", 32'(word_cnt), 32'd3);

        cap.delete();
        send(16'h002D, 4'd6);
        fork
            begin
                repeat (2) @(posedge clk);
                #1 fifo_full = 1'b1;
                repeat (3) @(posedge clk);
                #1 fifo_full = 1'b0;
            end
        join_none
        run_out(n);
        check("bp_cycles", 32'(n), 32'd9);
        check_seq("bp_seq", 16'h002D, 6);

        cap.delete();
        send(16'h0001, 4'd0);
        run_out(n);
        check("prec0_cycles", 32'(n), 32'd1);
        check_seq("prec0_seq", 16'h0001, 1);

        cap.delete();
        send(16'h7FFF, 4'd15);
        run_out(n);
        check("prec15_cycles", 32'(n), 32'd15);
        check_seq("prec15_seq", 16'h7FFF, 15);
        check("prec15_word_cnt", 32'(word_cnt), 32'd6);

        send(16'h00B5, 4'd8);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_bit_valid", 32'(bit_valid), 32'd0);
        check("async_bit_out", 32'(bit_out), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        check("async_word_cnt", 32'(word_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        cap.delete();
        check("post_rst_busy", 32'(busy), 32'd0);
        send(16'h0003, 4'd2);
        check("post_rst_word_cnt", 32'(word_cnt), 32'd0);
        run_out(n);
        check_seq("post_rst_seq", 16'h0003, 2);
        check("post_rst_word_cnt_done", 32'(word_cnt), 32'd1);

        rand_ff = 1'b1;
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(16'($urandom), 4'($urandom_range(0, 15)));
        end
        rand_ff = 1'b0;
        @(posedge clk);
        #2 fifo_full = 1'b0;
        run_out(n);
        check("rand_word_cnt", 32'(word_cnt), 32'd201);
        check("rand_sb_drained", 32'(sb_exp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder for the bit-serial weight FIFO in the FP-INT MAC datapath.
- Accepts parallel INT operand words over a valid/ready handshake.
- Emits each word LSB-first, one bit per cycle, for `precision` bits, directly onto the FIFO's write interface (wr_en/din), and honours the FIFO's full flag as backpressure.
- A one-word pending register hides the reload bubble, so consecutive words stream with no idle cycle.

Parameters:
- DATA_W, 16, parallel operand width; equals the FIFO depth.
- PREC_W, 4, width of the precision field.

Ports:
- clk        input   1        clock
- rst        input   1        asynchronous, active-low reset
- in_valid   input   1        in_data/in_prec valid
- in_ready   output  1        block can accept a word
- in_data    input   DATA_W   parallel INT operand, two's complement, low in_prec bits significant
- in_prec    input   PREC_W   bit count for this word (1..15); 0 is treated as 1
- fifo_full  input   1        FIFO full flag (backpressure)
- bit_valid  output  1        FIFO wr_en
- bit_out    output  1        FIFO din
- bit_last   output  1        current bit is the word's final (sign) bit
- busy       output  1        active or pending word held
- word_cnt   output  16       words fully emitted since reset, wraps at 2^16

Behaviour:
- Registers:
  - act_sr[DATA_W], act_cnt[PREC_W], act_valid.
  - pend_data[DATA_W], pend_prec[PREC_W], pend_valid.
  - word_cnt.
- States:
  - IDLE (act_valid=0).
  - SHIFT (act_valid=1).
- Combinational outputs:
  - bit_out = act_sr[0]
  - bit_valid = act_valid & ~fifo_full
  - bit_last = act_valid & (act_cnt == 1)
  - in_ready = ~pend_valid
  - busy = act_valid | pend_valid
- Accept: in_valid & in_ready at a rising edge. Precision is sampled with the data; an effective precision of 0 becomes 1. A later in_prec change never affects a held word.
- Emit: when bit_valid=1 at an edge:
  - act_sr shifts right by 1 (zero fill).
  - act_cnt decrements.
  - If bit_last, the word completes and word_cnt increments.
- Stall: when fifo_full=1:
  - act_sr and act_cnt hold.
  - bit_valid=0.
  - Input acceptance still proceeds while pend_valid=0.
- Load priority at an edge:
  - IDLE + accept: the word goes directly to act; pend stays empty.
  - SHIFT, no completion, + accept: the word goes to pend.
  - SHIFT, completion, pend_valid=1: pend moves to act and pend_valid clears. in_ready was 0 that cycle, so no accept is possible.
  - SHIFT, completion, pend_valid=0, + accept: the new word goes directly to act.
  - SHIFT, completion, no word available: transition to IDLE.
- Latency:
  - Word accepted at edge N while IDLE: bit 0 is presented during cycle N+1. bit_valid=1 unless fifo_full.
  - Back-to-back words: zero bubble cycles between the last bit of word k and bit 0 of word k+1.
- Throughput: 1 bit/cycle without backpressure. A p-bit word occupies exactly p non-stalled cycles.
- Boundaries:
  - Bits above in_prec-1 are never emitted.
  - fifo_full asserted on the completing cycle: completion is deferred until the bit is actually written.
- Reset (async, any time, including mid-word):
  - act_valid=0, pend_valid=0, act_sr=0, act_cnt=0, pend_*=0, word_cnt=0.
  - Resulting outputs: bit_valid=0, bit_out=0, bit_last=0, busy=0, in_ready=1.
  - Partial words are discarded. No bit is emitted on the first edge after release unless a word was accepted.

Decomposition:
- Shared package (mac_pkg):
  - DATA_W and PREC_W constants.
  - State enum {IDLE, SHIFT}.
  - Helper function eff_prec(p) = (p==0) ? 1 : p.
- Sub-module: word_slot (data + prec + valid holding register with load/clear), instantiated twice: once for the active slot (with shift/decrement enables) and once for the pending slot.
- FSM, handshake and word_cnt stay in the top level.

Test Plan:
- Single word: in_data=16'h00B5, prec=8, fifo_full=0.
  - bit_valid is high for 8 consecutive cycles starting the cycle after accept.
  - bit_out sequence is 1,0,1,0,1,1,0,1.
  - bit_last is high only on the 8th bit; word_cnt=1; then IDLE with busy=0.
- Back-to-back: words 4'h9 (prec 4) and 4'h6 (prec 4) presented with in_valid held high.
  - Output is 1,0,0,1,0,1,1,0 with no gap.
  - in_ready drops while pend is full; word_cnt=2.
- Backpressure: prec=6, in_data=6'h2D, fifo_full=1 for 3 cycles after the 2nd bit.
  - bit_valid=0 and bit_out is held during the stall.
  - Full sequence is 1,0,1,1,0,1; completion is delayed by exactly 3 cycles.
- Precision 0 and 15:
  - in_prec=0 with in_data=1: exactly one bit (1) with bit_last=1.
  - in_prec=15 with in_data=16'h7FFF: 15 ones, and bit 15 is never emitted.
- Reset mid-word: assert rst after 3 of 8 bits.
  - Outputs go to reset values immediately, asynchronously.
  - After release, a new word streams correctly; word_cnt=0 before that word completes.
- Scoreboard with the FIFO model: 200 random words with random prec and random fifo_full.
  - The reassembled words equal the inputs masked to prec.
  - No write ever occurs while fifo_full=1.
